// File: rtl/vector_transpose4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_transpose4 : ping-pong 4x4 complex corner-turn (rows in, cols out) |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`ifndef SFPWIDTH
`define SFPWIDTH 16
`endif

module vector_transpose4 #(
  parameter int formatWidth = `SFPWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [formatWidth*4-1:0] in_real,
  input  logic [formatWidth*4-1:0] in_imag,
  input  logic                     out_ready,
  output logic                     out_start,
  output logic [formatWidth*4-1:0] out_real,
  output logic [formatWidth*4-1:0] out_imag,
  output logic [1:0]               out_col,
  output logic                     tile_done,
  output logic                     busy,
  output logic                     overflow
);

  localparam int LW = formatWidth * 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Storage indexed [bank][row]; never reset, contents are don't-care until written
  logic [LW-1:0] mem_real [2][4];
  logic [LW-1:0] mem_imag [2][4];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    wr_row;
  logic [1:0]    rd_col;
  logic [1:0]    bank_full;
  logic          wr_accept;
  logic          wr_last;
  logic          rd_issue;
  logic          rd_last;
  logic [LW-1:0] col_real;
  logic [LW-1:0] col_imag;

  always_comb begin
    wr_accept = in_valid & ~bank_full[wr_bank];
    wr_last   = wr_accept & (wr_row == 2'd3);
  end

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          rd_issue = 1'b1;
          if (rd_col == 2'd3) begin
            rd_last   = 1'b1;
            state_nxt = bank_full[~rd_bank] ? DRAIN : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gather column rd_col: lane r of the output is lane rd_col of row r
  always_comb begin
    col_real = '0;
    col_imag = '0;
    for (int r = 0; r < 4; r++) begin
      col_real[formatWidth*r +: formatWidth] = mem_real[rd_bank][r][formatWidth*int'(rd_col) +: formatWidth];
      col_imag[formatWidth*r +: formatWidth] = mem_imag[rd_bank][r][formatWidth*int'(rd_col) +: formatWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_real[wr_bank][wr_row] <= in_real;
      mem_imag[wr_bank][wr_row] <= in_imag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= 2'd0;
      rd_col    <= 2'd0;
      bank_full <= 2'b00;
      out_start <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_col   <= 2'd0;
      tile_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_start <= rd_issue;
      tile_done <= rd_last;
      if (rd_issue) begin
        out_real <= col_real;
        out_imag <= col_imag;
        out_col  <= rd_col;
        rd_col   <= rd_col + 2'd1;
      end
      if (rd_last) begin
        rd_bank            <= ~rd_bank;
        bank_full[rd_bank] <= 1'b0;
      end
      if (wr_accept) begin
        wr_row <= wr_row + 2'd1;
      end
      // A write can only complete the bank that is not being drained, so set and clear never collide
      if (wr_last) begin
        wr_bank            <= ~wr_bank;
        bank_full[wr_bank] <= 1'b1;
      end
      if (in_valid && !wr_accept) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = bank_full[0] | bank_full[1] | (wr_row != 2'd0) | (state == DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_vector_transpose4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_transpose4 : self-checking bench for vector_transpose4          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vector_transpose4;

  localparam int W  = 16;
  localparam int LW = 4 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [LW-1:0] in_real = '0;
  logic [LW-1:0] in_imag = '0;
  logic          out_ready = 1'b0;
  logic          out_start;
  logic [LW-1:0] out_real;
  logic [LW-1:0] out_imag;
  logic [1:0]    out_col;
  logic          tile_done;
  logic          busy;
  logic          overflow;

  vector_transpose4 #(.formatWidth(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_ready(out_ready), .out_start(out_start), .out_real(out_real), .out_imag(out_imag),
    .out_col(out_col), .tile_done(tile_done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r of a tile with base b: lane c holds b + 16r + c
  function automatic logic [LW-1:0] rowval(input int base, input int r);
    logic [LW-1:0] v;
    for (int c = 0; c < 4; c++) v[W*c +: W] = 16'(base + 16*r + c);
    return v;
  endfunction

  // Column c of the same tile: lane r holds b + 16r + c
  function automatic logic [LW-1:0] colval(input int base, input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < 4; r++) v[W*r +: W] = 16'(base + 16*r + c);
    return v;
  endfunction

  typedef struct {
    int v; int row; int rdy; int e_start; int e_col; int e_done; int e_busy; int e_dv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int v, input int row, input int rdy, input int st,
                              input int col, input int dn, input int bz, input int dv);
    vec_t e;
    e = '{v, row, rdy, st, col, dn, bz, dv};
    tbl.push_back(e);
  endfunction

  // Scoreboard state for the randomized phase
  logic [LW-1:0] prow_re[$];
  logic [LW-1:0] prow_im[$];
  logic [LW-1:0] exq_re[$];
  logic [LW-1:0] exq_im[$];
  int            pending = 0;
  int            emitted = 0;
  bit            exp_ovf = 1'b0;
  logic [LW-1:0] last_re = '0;
  logic [LW-1:0] last_im = '0;

  task automatic rnd_step();
    logic [LW-1:0] a, b, cre, cim;
    tick();
    if (in_valid) begin
      if (pending < 2) begin
        prow_re.push_back(in_real);
        prow_im.push_back(in_imag);
        if (prow_re.size() == 4) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
              a = prow_re[r];
              b = prow_im[r];
              cre[W*r +: W] = a[W*c +: W];
              cim[W*r +: W] = b[W*c +: W];
            end
            exq_re.push_back(cre);
            exq_im.push_back(cim);
          end
          prow_re.delete();
          prow_im.delete();
          pending++;
        end
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (out_start) begin
      chk("rnd_start_needs_ready", out_ready, 1);
      if (exq_re.size() == 0) begin
        chk("rnd_unexpected_column", 1, 0);
      end else begin
        chk("rnd_col_real", out_real, exq_re.pop_front());
        chk("rnd_col_imag", out_imag, exq_im.pop_front());
        chk("rnd_out_col", out_col, emitted % 4);
        chk("rnd_tile_done", tile_done, (emitted % 4) == 3);
        if (tile_done) pending--;
        emitted++;
      end
      last_re = out_real;
      last_im = out_imag;
    end else begin
      chk("rnd_hold", {tile_done, out_real ^ out_imag}, {1'b0, last_re ^ last_im});
    end
    chk("rnd_overflow", overflow, exp_ovf);
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_start", out_start, 0);
    chk("reset_out_real", out_real, 0);
    chk("reset_out_imag", out_imag, 0);
    chk("reset_out_col", out_col, 0);
    chk("reset_tile_done", tile_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    rst = 1'b0;

    // Single tile, then a backpressured tile (ready 1,0,0,1,...)
    add(1,0,1, 0,0,0,1,0); add(1,1,1, 0,0,0,1,0); add(1,2,1, 0,0,0,1,0); add(1,3,1, 0,0,0,1,0);
    add(0,0,1, 0,0,0,1,0); add(0,0,1, 1,0,0,1,1); add(0,0,1, 1,1,0,1,1); add(0,0,1, 1,2,0,1,1);
    add(0,0,1, 1,3,1,0,1); add(0,0,1, 0,3,0,0,1);
    add(1,0,0, 0,3,0,1,1); add(1,1,0, 0,3,0,1,1); add(1,2,0, 0,3,0,1,1); add(1,3,0, 0,3,0,1,1);
    add(0,0,0, 0,3,0,1,1); add(0,0,1, 1,0,0,1,1); add(0,0,0, 0,0,0,1,1); add(0,0,0, 0,0,0,1,1);
    add(0,0,1, 1,1,0,1,1); add(0,0,0, 0,1,0,1,1); add(0,0,0, 0,1,0,1,1); add(0,0,1, 1,2,0,1,1);
    add(0,0,0, 0,2,0,1,1); add(0,0,0, 0,2,0,1,1); add(0,0,1, 1,3,1,0,1); add(0,0,0, 0,3,0,0,1);
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].v[0];
      in_real   = rowval(0, tbl[i].row);
      in_imag   = rowval('h100, tbl[i].row);
      out_ready = tbl[i].rdy[0];
      tick();
      chk($sformatf("tbl%0d_start", i), out_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_col", i), out_col, tbl[i].e_col);
      chk($sformatf("tbl%0d_done", i), tile_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_dv != 0) begin
        chk($sformatf("tbl%0d_real", i), out_real, colval(0, tbl[i].e_col));
        chk($sformatf("tbl%0d_imag", i), out_imag, colval('h100, tbl[i].e_col));
      end
    end
    in_valid = 1'b0;

    // Back-to-back: 8 rows in 8 cycles, columns stream without a gap
    for (int k = 0; k < 14; k++) begin
      in_valid  = (k < 8);
      in_real   = rowval((k >= 4) ? 'h80 : 0, k % 4);
      in_imag   = rowval((k >= 4) ? 'h180 : 'h100, k % 4);
      out_ready = 1'b1;
      tick();
      chk($sformatf("b2b%0d_start", k), out_start, (k >= 5 && k <= 12));
      if (k >= 5 && k <= 12) begin
        chk($sformatf("b2b%0d_col", k), out_col, (k - 5) % 4);
        chk($sformatf("b2b%0d_done", k), tile_done, ((k - 5) % 4) == 3);
        chk($sformatf("b2b%0d_real", k), out_real, colval((k >= 9) ? 'h80 : 0, (k - 5) % 4));
        chk($sformatf("b2b%0d_imag", k), out_imag, colval((k >= 9) ? 'h180 : 'h100, (k - 5) % 4));
      end
    end
    in_valid = 1'b0;
    chk("b2b_overflow", overflow, 0);
    chk("b2b_busy_after", busy, 0);

    // Overflow: 9 rows with no drain, ninth dropped
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_real  = rowval((k >= 8) ? 'h200 : (k >= 4) ? 'h80 : 0, k % 4);
      in_imag  = rowval((k >= 8) ? 'h300 : (k >= 4) ? 'h180 : 'h100, k % 4);
      tick();
      if (k == 7) chk("ovf_before_ninth", overflow, 0);
    end
    in_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_busy", busy, 1);
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_start) begin
        if (n < 8) begin
          chk($sformatf("ovf_col%0d_real", n), out_real, colval((n >= 4) ? 'h80 : 0, n % 4));
          chk($sformatf("ovf_col%0d_imag", n), out_imag, colval((n >= 4) ? 'h180 : 'h100, n % 4));
          chk($sformatf("ovf_col%0d_idx", n), out_col, n % 4);
        end
        n++;
      end
    end
    chk("ovf_column_count", n, 8);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_busy_after", busy, 0);

    // Asynchronous reset mid-drain with a partial second tile pending
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_real  = rowval('h40, k % 4);
      in_imag  = rowval('h140, k % 4);
      tick();
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_start) seen = 1'b1;
      else tick();
    end
    chk("midrst_saw_start", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {out_start, out_col, tile_done, busy, overflow}, 0);
    chk("midrst_real", out_real, 0);
    chk("midrst_imag", out_imag, 0);
    #2 rst = 1'b0;

    // Randomized traffic against the scoreboard (model starts empty: partial tile discarded)
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom % 2);
      in_real   = {$urandom, $urandom};
      in_imag   = {$urandom, $urandom};
      out_ready = ((cyc / 50) % 2 == 1) ? ($urandom % 4 != 0) : ($urandom % 3 == 0);
      rnd_step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) rnd_step();
    chk("rnd_all_drained", exq_re.size(), 0);
    chk("rnd_final_busy", busy, prow_re.size() != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
